// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage RV32 pipeline: load-use stall, taken-branch
// flush, multi-cycle MDU occupancy stall, EX-stage forwarding selects and a
// saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int MDU_LATENCY = 32,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic [4:0]           rs1_e,
    input  logic [4:0]           rs2_e,
    input  logic [4:0]           rd_e,
    input  logic                 mem_to_reg_e,
    input  logic                 mdu_start_e,
    input  logic                 pc_src_e,
    input  logic [4:0]           rd_m,
    input  logic [4:0]           rd_w,
    input  logic                 reg_write_m,
    input  logic                 reg_write_w,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 flush_m,
    output logic [1:0]           fwd_a_e,
    output logic [1:0]           fwd_b_e,
    output logic                 mdu_busy,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt
);

    localparam int CW = $clog2(MDU_LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LATENCY - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [CNT_WIDTH-1:0] perf_reg;
    logic                 stall_mdu;
    logic                 lw_stall;
    logic [4:0]           src_e [2];
    logic [1:0]           fwd   [2];

    assign src_e[0] = rs1_e;
    assign src_e[1] = rs2_e;

    // Forwarding select per EX source; MEM result takes priority over WB.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                fwd[gi] = 2'b00;
                if (!rst) begin
                    if (reg_write_m && rd_m != 5'd0 && rd_m == src_e[gi])
                        fwd[gi] = 2'b10;
                    else if (reg_write_w && rd_w != 5'd0 && rd_w == src_e[gi])
                        fwd[gi] = 2'b01;
                end
            end
        end
    endgenerate

    assign fwd_a_e = fwd[0];
    assign fwd_b_e = fwd[1];

    // MDU occupancy state and down-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // MDU next state: the start cycle stalls from IDLE, then BUSY covers the
    // remaining MDU_LATENCY-1 cycles while the op sits held in EX.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (mdu_start_e) begin
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - CNT_LAST;
                if (cnt_reg == CNT_LAST)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign stall_mdu = (state_reg == BUSY) || (state_reg == IDLE && mdu_start_e);
    assign lw_stall  = mem_to_reg_e && rd_e != 5'd0 && (rd_e == rs1_d || rd_e == rs2_d);
    assign mdu_busy  = (state_reg == BUSY);

    // Stall/flush decode: MDU occupancy beats a taken branch, which beats
    // load-use (the ID instruction is wrong-path so its stall is moot).
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (!rst) begin
            if (stall_mdu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lw_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Saturating count of cycles in which fetch is held.
    always_ff @(posedge clk) begin
        if (rst)
            perf_reg <= '0;
        else if (stall_f && perf_reg != '1)
            perf_reg <= perf_reg + 1'b1;
    end

    assign perf_stall_cnt = perf_reg;

endmodule
